// File: rtl/cc_speed_tick_generator.sv
// Multi-channel programmable speed-tick generator: per-lane period countdown with periodic or one-shot tick.
// Latency: tick registered, high the cycle after the expiry edge; T0 is a direct decode of the counter register.
// Backpressure: none; the global enable pauses every counter, and loads are always accepted.
module cc_speed_tick_generator #(
  parameter int SPEEDTICK_DATAWIDTH = 23,
  parameter int SPEEDTICK_CHANNELS  = 4
) (
  input  logic                                            CC_SPEEDTICK_CLOCK_50,
  input  logic                                            CC_SPEEDTICK_RESET_InLow,
  input  logic                                            CC_SPEEDTICK_enable_In,
  input  logic [SPEEDTICK_CHANNELS-1:0]                   CC_SPEEDTICK_load_InBUS,
  input  logic [SPEEDTICK_CHANNELS*SPEEDTICK_DATAWIDTH-1:0] CC_SPEEDTICK_period_InBUS,
  input  logic [SPEEDTICK_CHANNELS-1:0]                   CC_SPEEDTICK_mode_InBUS,
  output logic [SPEEDTICK_CHANNELS-1:0]                   CC_SPEEDTICK_tick_OutBUS,
  output logic [SPEEDTICK_CHANNELS-1:0]                   CC_SPEEDTICK_T0_OutBUS
);

  localparam int DW = SPEEDTICK_DATAWIDTH;
  localparam int CH = SPEEDTICK_CHANNELS;
  localparam logic [DW-1:0] CNT_ZERO = '0;
  localparam logic [DW-1:0] CNT_ONE  = {{(DW-1){1'b0}}, 1'b1};

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e          state_q  [CH];
  state_e          state_d  [CH];
  logic [DW-1:0]   period_q [CH];
  logic [DW-1:0]   period_d [CH];
  logic [DW-1:0]   count_q  [CH];
  logic [DW-1:0]   count_d  [CH];
  logic [CH-1:0]   mode_q;
  logic [CH-1:0]   mode_d;
  logic [CH-1:0]   tick_q;
  logic [CH-1:0]   tick_d;

  // Per-channel next state: load wins over countdown; expiry reloads (periodic) or parks at zero (one-shot).
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      state_d[i]  = state_q[i];
      period_d[i] = period_q[i];
      count_d[i]  = count_q[i];
      mode_d[i]   = mode_q[i];
      tick_d[i]   = 1'b0;
      if (CC_SPEEDTICK_load_InBUS[i]) begin
        period_d[i] = CC_SPEEDTICK_period_InBUS[i*DW +: DW];
        count_d[i]  = CC_SPEEDTICK_period_InBUS[i*DW +: DW];
        mode_d[i]   = CC_SPEEDTICK_mode_InBUS[i];
        state_d[i]  = (CC_SPEEDTICK_period_InBUS[i*DW +: DW] != CNT_ZERO) ? RUN : IDLE;
      end else if (state_q[i] == RUN && CC_SPEEDTICK_enable_In) begin
        if (count_q[i] == CNT_ONE) begin
          tick_d[i] = 1'b1;
          if (mode_q[i]) begin
            count_d[i] = CNT_ZERO;
            state_d[i] = IDLE;
          end else begin
            count_d[i] = period_q[i];
          end
        end else begin
          // RUN always holds a count >= 1, so this never wraps.
          count_d[i] = count_q[i] - CNT_ONE;
        end
      end
    end
  end

  // Channel state registers with asynchronous active-low clear.
  always_ff @(posedge CC_SPEEDTICK_CLOCK_50 or negedge CC_SPEEDTICK_RESET_InLow) begin
    if (!CC_SPEEDTICK_RESET_InLow) begin
      for (int i = 0; i < CH; i++) begin
        state_q[i]  <= IDLE;
        period_q[i] <= CNT_ZERO;
        count_q[i]  <= CNT_ZERO;
      end
      mode_q <= '0;
      tick_q <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        state_q[i]  <= state_d[i];
        period_q[i] <= period_d[i];
        count_q[i]  <= count_d[i];
      end
      mode_q <= mode_d;
      tick_q <= tick_d;
    end
  end

  // Zero indication decoded straight from the counter register.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      CC_SPEEDTICK_T0_OutBUS[i] = (count_q[i] == CNT_ZERO);
    end
  end

  assign CC_SPEEDTICK_tick_OutBUS = tick_q;

endmodule

// File: tb/tb_cc_speed_tick_generator.sv
// Directed bench for cc_speed_tick_generator: cycle table plus parallel and mid-run reset sequences.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// No DUT handshakes are awaited, so every sequence runs a fixed number of cycles.
module tb_cc_speed_tick_generator;

  localparam int DW = 23;
  localparam int CH = 4;

  logic              clk;
  logic              rst_n;
  logic              en;
  logic [CH-1:0]     ld;
  logic [CH*DW-1:0]  per;
  logic [CH-1:0]     md;
  logic [CH-1:0]     tick;
  logic [CH-1:0]     t0;

  int n_cmp;
  int n_bad;

  cc_speed_tick_generator #(
    .SPEEDTICK_DATAWIDTH (DW),
    .SPEEDTICK_CHANNELS  (CH)
  ) dut (
    .CC_SPEEDTICK_CLOCK_50     (clk),
    .CC_SPEEDTICK_RESET_InLow  (rst_n),
    .CC_SPEEDTICK_enable_In    (en),
    .CC_SPEEDTICK_load_InBUS   (ld),
    .CC_SPEEDTICK_period_InBUS (per),
    .CC_SPEEDTICK_mode_InBUS   (md),
    .CC_SPEEDTICK_tick_OutBUS  (tick),
    .CC_SPEEDTICK_T0_OutBUS    (t0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          en;
    logic [CH-1:0] ld;
    logic [CH-1:0] md;
    int            p0, p1, p2, p3;
    logic [CH-1:0] tk;
    logic [CH-1:0] z;
  } vec_t;

  vec_t tbl [30];

  function automatic vec_t mk(logic e, logic [3:0] l, logic [3:0] m,
                              int a, int b, int c, int d,
                              logic [3:0] tk_e, logic [3:0] z_e);
    vec_t v;
    v.en = e; v.ld = l; v.md = m;
    v.p0 = a; v.p1 = b; v.p2 = c; v.p3 = d;
    v.tk = tk_e; v.z = z_e;
    return v;
  endfunction

  function automatic logic [CH*DW-1:0] pk(int a, int b, int c, int d);
    logic [CH*DW-1:0] r;
    r = '0;
    r[0*DW +: DW] = DW'(a);
    r[1*DW +: DW] = DW'(b);
    r[2*DW +: DW] = DW'(c);
    r[3*DW +: DW] = DW'(d);
    return r;
  endfunction

  task automatic chk(string name, int idx, logic [3:0] act, logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %b expected %b", name, idx, act, exp);
    end
  endtask

  // One clock: drive inputs, pass the rising edge, settle 1 unit after it.
  task automatic step(logic e, logic [3:0] l, logic [3:0] m, logic [CH*DW-1:0] p);
    en = e; ld = l; md = m; per = p;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp_tk;
    int         vv [4];

    n_cmp = 0;
    n_bad = 0;
    en = 1'b0; ld = '0; md = '0; per = '0;

    // Power-on reset.
    rst_n = 1'b0;
    #1;
    chk("rst_tick", 0, tick, 4'b0000);
    chk("rst_t0",   0, t0,   4'b1111);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, 4'b0000, 4'b0000, '0);
    chk("idle_tick", 0, tick, 4'b0000);
    chk("idle_t0",   0, t0,   4'b1111);

    // ch0 periodic V=3, ch1 one-shot V=4, pause, ch2 V=5 with 3-cycle pause,
    // ch0 reload on its expiry edge, ch3 V=0, and mode change without load.
    tbl[0]  = mk(1, 4'b0011, 4'b0010, 3, 4, 0, 0, 4'b0000, 4'b1100);
    tbl[1]  = mk(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b1100);
    tbl[2]  = mk(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b1100);
    tbl[3]  = mk(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0001, 4'b1100);
    tbl[4]  = mk(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0010, 4'b1110);
    tbl[5]  = mk(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b1110);
    tbl[6]  = mk(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0001, 4'b1110);
    tbl[7]  = mk(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b1110);
    tbl[8]  = mk(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b1110);
    tbl[9]  = mk(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0001, 4'b1110);
    tbl[10] = mk(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b1110);
    tbl[11] = mk(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b1110);
    tbl[12] = mk(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b1110);
    tbl[13] = mk(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0001, 4'b1110);
    tbl[14] = mk(1, 4'b0100, 4'b0000, 0, 0, 5, 0, 4'b0000, 4'b1010);
    tbl[15] = mk(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b1010);
    tbl[16] = mk(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0001, 4'b1010);
    tbl[17] = mk(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b1010);
    tbl[18] = mk(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b1010);
    tbl[19] = mk(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b1010);
    tbl[20] = mk(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b1010);
    tbl[21] = mk(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b1010);
    tbl[22] = mk(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0101, 4'b1010);
    tbl[23] = mk(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b1010);
    tbl[24] = mk(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b1010);
    tbl[25] = mk(1, 4'b1001, 4'b0000, 2, 0, 0, 0, 4'b0000, 4'b1010);
    tbl[26] = mk(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b1010);
    tbl[27] = mk(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0101, 4'b1010);
    tbl[28] = mk(1, 4'b0000, 4'b1111, 0, 0, 0, 0, 4'b0000, 4'b1010);
    tbl[29] = mk(1, 4'b0000, 4'b1111, 0, 0, 0, 0, 4'b0001, 4'b1010);

    for (int s = 0; s < 30; s++) begin
      step(tbl[s].en, tbl[s].ld, tbl[s].md, pk(tbl[s].p0, tbl[s].p1, tbl[s].p2, tbl[s].p3));
      chk("tbl_tick", s, tick, tbl[s].tk);
      chk("tbl_t0",   s, t0,   tbl[s].z);
    end

    // All channels loaded together with V=1,2,3,4 periodic.
    vv[0] = 1; vv[1] = 2; vv[2] = 3; vv[3] = 4;
    step(1'b1, 4'b1111, 4'b0000, pk(1, 2, 3, 4));
    chk("par_load_tick", 0, tick, 4'b0000);
    chk("par_load_t0",   0, t0,   4'b0000);
    for (int n = 1; n <= 24; n++) begin
      step(1'b1, 4'b0000, 4'b0000, '0);
      for (int c = 0; c < CH; c++) exp_tk[c] = ((n % vv[c]) == 0);
      chk("par_tick", n, tick, exp_tk);
      chk("par_t0",   n, t0,   4'b0000);
    end

    // Asynchronous reset mid-count: ch0 loaded with 10, five counts bring it to 5.
    step(1'b1, 4'b1111, 4'b0000, pk(10, 0, 0, 0));
    repeat (5) step(1'b1, 4'b0000, 4'b0000, '0);
    chk("pre_rst_t0", 0, t0, 4'b1110);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tick", 0, tick, 4'b0000);
    chk("mid_rst_t0",   0, t0,   4'b1111);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int n = 0; n < 15; n++) begin
      step(1'b1, 4'b0000, 4'b0000, '0);
      chk("post_rst_tick", n, tick, 4'b0000);
      chk("post_rst_t0",   n, t0,   4'b1111);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cc_speed_tick_generator.md
# cc_speed_tick_generator

Multi-channel programmable speed-tick generator for the Frogger lane engine, successor to the single-register speed zero-comparator. Each channel stores a loaded speed period, counts it down while globally enabled, and emits a one-cycle tick on expiry, either periodically or once. The per-channel zero indication is retained, now registered and multi-channel. Lane movement logic consumes the ticks; the game controller owns loads and enable.

## Interface
- SPEEDTICK_DATAWIDTH, 23: width of each channel's period and counter (unsigned).
- SPEEDTICK_CHANNELS, 4: number of independent channels (lanes).

- CC_SPEEDTICK_CLOCK_50  input  1  system clock; all state changes on rising edge.
- CC_SPEEDTICK_RESET_InLow  input  1  asynchronous, active-low reset.
- CC_SPEEDTICK_enable_In  input  1  global run/pause; 1 = counters advance.
- CC_SPEEDTICK_load_InBUS  input  CHANNELS  per-channel load strobe, bit i for channel i.
- CC_SPEEDTICK_period_InBUS  input  CHANNELS*DATAWIDTH  packed periods; channel i at bits [i*DATAWIDTH +: DATAWIDTH].
- CC_SPEEDTICK_mode_InBUS  input  CHANNELS  per-channel mode sampled on load: 0 periodic, 1 one-shot.
- CC_SPEEDTICK_tick_OutBUS  output  CHANNELS  registered one-cycle expiry pulse per channel.
- CC_SPEEDTICK_T0_OutBUS  output  CHANNELS  bit i = 1 when channel i counter is zero (idle/expired), else 0.

## Operation
- Per channel registers: period P, counter C, stored mode M, state {IDLE, RUN}, tick flop.
- Reset (async, any time, including mid-count): P=0, C=0, M=0, state IDLE, tick_OutBUS=0, T0_OutBUS=all ones.
- Load (load bit i = 1 at an edge): P<=V, C<=V, M<=mode bit i; state RUN if V!=0, else IDLE. Load has priority over decrement/expiry in that cycle; tick is 0 in the cycle after a load edge. Load is accepted regardless of enable.
- V=0 load: channel disabled; C=0, T0=1, never ticks.
- RUN, enable=1, C>1: C<=C-1, tick<=0.
- RUN, enable=1, C==1 (expiry): tick<=1; periodic: C<=P, stay RUN; one-shot: C<=0, state IDLE.
- RUN, enable=0: C, state hold; tick<=0.
- IDLE: C holds; tick<=0.
- mode_InBUS changes without load are ignored.
- Channels fully independent; simultaneous loads/expiries on different channels all take effect in the same cycle.
- Arithmetic: unsigned DATAWIDTH-bit; max period 2^DATAWIDTH-1; no wrap possible since decrement never occurs from 0.

## Timing
- T0_OutBUS is a pure decode of the C register (no extra latency): changes in the cycle following the edge that changes C.
- First tick: load at edge k with V, enable held 1 → tick high for exactly one cycle after edge k+V.
- Periodic: subsequent ticks every V enabled cycles; V=1 gives tick continuously high.
- Pausing: each enable=0 cycle delays the next tick by one cycle; a tick pending when enable falls is not emitted until count resumes.
- Load during RUN (incl. on the expiry edge): restarts from new V; the expiry tick of that edge is suppressed.
- Periodic running channel never shows T0=1 (C reloads to P≥1).

## Test plan
- Reset check: assert RESET_InLow=0 mid-run with channel 0 at C=5 → tick_OutBUS=0, T0_OutBUS=4'b1111 immediately, no tick after release.
- Periodic: load ch0 V=3 mode 0, enable=1 → tick0 high one cycle after edges k+3, k+6, k+9; T0[0]=0 throughout.
- One-shot: load ch1 V=4 mode 1 → single tick1 after edge k+4; T0[1]=1 from the following cycle; no further ticks over 20 cycles.
- Pause: ch2 V=5 periodic, drop enable for 3 cycles after 2 counts → first tick shifted to after edge k+8; C holds during pause.
- Zero/disable and collision: load ch3 V=0 → T0[3]=1, no ticks; reload ch0 V=2 on its expiry edge → no tick that cycle, next tick 2 cycles later.
- Parallel: load all channels V=1,2,3,4 periodic simultaneously → each tick_i period equals V_i over 24 cycles, coincident ticks all asserted together.
